ddr_wr_arbiter: RTL and testbench

Round-robin scheduler that shares the single PL DDR write port among NCH acquisition channels. Each channel buffers LVDS words in its own FIFO and raises a request once a full block is queued. The arbiter grants one channel at a time and issues the block command (start/addr/length). It then streams exactly one block of words from that channel's FIFO to the DDR write engine. Each channel has its own ring-buffer region in DDR, and the arbiter tracks the write address within it.

---
 rtl/ddr_wr_arbiter_pkg.sv | 25 ++
 rtl/ddr_wr_arbiter_if.sv | 32 +++
 rtl/ddr_wr_arbiter_rr_pick.sv | 36 +++
 rtl/ddr_wr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ddr_wr_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_wr_arbiter_pkg.sv
// Shared types and defaults for the DDR write-port arbiter slice.
package ddr_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_XFER,
        ST_DRAIN
    } arb_state_t;

    localparam int unsigned DEF_BLK_WORDS    = 8000;
    localparam int unsigned DEF_BLK_BYTES    = 32000;
    localparam int unsigned DEF_REGION_BYTES = 48_000_000;

    // Index width for an n-entry channel set; never below 1 bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ddr_wr_arbiter_if.sv
// Command/data port between the arbiter and the PL DDR write engine.
interface ddr_wr_arbiter_if;

    logic        ddr_wr_busy;
    logic        ddr_wr_afull;
    logic        pl_ddr_wr_start;
    logic [31:0] pl_ddr_wr_addr;
    logic [31:0] pl_ddr_wr_length;
    logic        pl_ddr_wr_en;
    logic [31:0] pl_ddr_wr_data;

    modport master (
        input  ddr_wr_busy,
        input  ddr_wr_afull,
        output pl_ddr_wr_start,
        output pl_ddr_wr_addr,
        output pl_ddr_wr_length,
        output pl_ddr_wr_en,
        output pl_ddr_wr_data
    );

    modport slave (
        output ddr_wr_busy,
        output ddr_wr_afull,
        input  pl_ddr_wr_start,
        input  pl_ddr_wr_addr,
        input  pl_ddr_wr_length,
        input  pl_ddr_wr_en,
        input  pl_ddr_wr_data
    );

endinterface

// File: rtl/ddr_wr_arbiter_rr_pick.sv
// Round-robin priority encoder: first requester after 'last', with wrap.
module rr_pick
    import ddr_wr_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned IW  = clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  last,
    output logic [NCH-1:0] gnt_oh,
    output logic [IW-1:0]  gnt_idx,
    output logic           valid
);

    int unsigned     cand;
    logic [IW-1:0]   cand_idx;

    // Scan last+1 .. last+NCH (mod NCH); the first hit wins.
    always_comb begin
        gnt_oh   = '0;
        gnt_idx  = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand     = (32'(last) + k) % NCH;
            cand_idx = IW'(cand);
            if (!valid && req[cand_idx]) begin
                valid            = 1'b1;
                gnt_idx          = cand_idx;
                gnt_oh[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// Round-robin sharing of the PL DDR write port among NCH FIFO channels.
module ddr_wr_arbiter
    import ddr_wr_pkg::*;
#(
    parameter int unsigned NCH          = 4,
    parameter int unsigned BLK_WORDS    = DEF_BLK_WORDS,
    parameter int unsigned BLK_BYTES    = DEF_BLK_BYTES,
    parameter int unsigned REGION_BYTES = DEF_REGION_BYTES
) (
    input  logic              pl_clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*32-1:0] ch_rd_data,
    output logic [NCH-1:0]    ch_rd_en,
    output logic [NCH-1:0]    ch_grant,
    output logic [NCH-1:0]    ch_blk_done,
    ddr_wr_arbiter_if.master  ddr
);

    localparam int unsigned IW       = clog2(NCH);
    localparam logic [13:0] LAST_CNT = 14'(BLK_WORDS - 1);
    localparam logic [31:0] LAST_OFF = 32'(REGION_BYTES - BLK_BYTES);

    arb_state_t      state;
    arb_state_t      state_nxt;

    logic [NCH-1:0]  pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   last_grant;
    logic [13:0]     rd_cnt;
    logic            drain_cnt;
    logic [31:0]     ch_off [NCH];
    logic [31:0]     wr_addr_q;
    logic [31:0]     wr_len_q;

    logic            grant_go;
    logic            pop_go;
    logic            drain_last;

    logic [NCH-1:0]  rd_en_d1;
    logic            wr_en_q;
    logic [31:0]     wr_data_q;
    logic [31:0]     mux_word;

    rr_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .req     (ch_req),
        .last    (last_grant),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .valid   (pick_valid)
    );

    assign grant_go   = (state == ST_IDLE) && pick_valid && !ddr.ddr_wr_busy;
    assign pop_go     = (state == ST_XFER) && !ddr.ddr_wr_afull;
    assign drain_last = (state == ST_DRAIN) && drain_cnt;

    // FSM state register.
    always_ff @(posedge pl_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant_go) state_nxt = ST_START;
            ST_START: state_nxt = ST_XFER;
            ST_XFER:  if (pop_go && (rd_cnt == LAST_CNT)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: command pulse, afull-gated FIFO pop, block-done pulse.
    always_comb begin
        ddr.pl_ddr_wr_start = (state == ST_START);
        ch_rd_en            = pop_go ? ch_grant : '0;
        ch_blk_done         = drain_last ? ch_grant : '0;
    end

    // Grant, command fields, word counter and per-channel ring offsets.
    always_ff @(posedge pl_clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_grant   <= '0;
            grant_idx  <= '0;
            last_grant <= IW'(NCH - 1);
            rd_cnt     <= '0;
            drain_cnt  <= 1'b0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                ch_off[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_go) begin
                        ch_grant  <= pick_oh;
                        grant_idx <= pick_idx;
                        wr_addr_q <= 32'(pick_idx) * REGION_BYTES + ch_off[pick_idx];
                        wr_len_q  <= 32'(BLK_BYTES);
                    end
                end
                ST_XFER: begin
                    if (pop_go) begin
                        rd_cnt <= (rd_cnt == LAST_CNT) ? '0 : rd_cnt + 14'd1;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt) begin
                        ch_off[grant_idx] <= (ch_off[grant_idx] == LAST_OFF)
                                             ? '0
                                             : ch_off[grant_idx] + 32'(BLK_BYTES);
                        last_grant        <= grant_idx;
                        ch_grant          <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // One-hot mux over the FIFO words that were popped last cycle.
    always_comb begin
        mux_word = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (rd_en_d1[i]) begin
                mux_word = mux_word | ch_rd_data[32*i +: 32];
            end
        end
    end

    // Two-stage write pipe: pop -> FIFO data valid -> registered DDR word.
    always_ff @(posedge pl_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_d1  <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            rd_en_d1 <= ch_rd_en;
            wr_en_q  <= |rd_en_d1;
            if (|rd_en_d1) begin
                wr_data_q <= mux_word;
            end
        end
    end

    assign ddr.pl_ddr_wr_addr   = wr_addr_q;
    assign ddr.pl_ddr_wr_length = wr_len_q;
    assign ddr.pl_ddr_wr_en     = wr_en_q;
    assign ddr.pl_ddr_wr_data   = wr_data_q;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Directed bench for ddr_wr_arbiter with scaled-down block/region sizes.
module tb_ddr_wr_arbiter;

    localparam int NCH = 4;
    localparam int BW  = 8;     // words per block
    localparam int BB  = 32;    // bytes per block
    localparam int RB  = 96;    // bytes per region (3 blocks)

    logic              pl_clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    ch_req;
    logic [NCH*32-1:0] ch_rd_data = '0;
    logic [NCH-1:0]    ch_rd_en;
    logic [NCH-1:0]    ch_grant;
    logic [NCH-1:0]    ch_blk_done;

    ddr_wr_arbiter_if ddr ();

    ddr_wr_arbiter #(
        .NCH          (NCH),
        .BLK_WORDS    (BW),
        .BLK_BYTES    (BB),
        .REGION_BYTES (RB)
    ) dut (
        .pl_clk      (pl_clk),
        .rst_n       (rst_n),
        .ch_req      (ch_req),
        .ch_rd_data  (ch_rd_data),
        .ch_rd_en    (ch_rd_en),
        .ch_grant    (ch_grant),
        .ch_blk_done (ch_blk_done),
        .ddr         (ddr)
    );

    always #5 pl_clk = ~pl_clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;
    int mptr    [NCH];   // FIFO model read pointers
    int exp_ptr [NCH];   // next word expected at the DDR side

    always @(posedge pl_clk) cyc <= cyc + 1;

    // FIFO model: word {channel, sequence} valid one cycle after the pop.
    always @(posedge pl_clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (ch_rd_en[c]) begin
                ch_rd_data[c*32 +: 32] <= {8'(c), 24'(mptr[c])};
                mptr[c] <= mptr[c] + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for a command pulse and check its fields.
    task automatic wait_start(input int ch, input int addr, input int budget, output int waited);
        bit found;
        found  = 0;
        waited = 0;
        for (int n = 1; n <= budget && !found; n++) begin
            @(negedge pl_clk);
            if (ddr.pl_ddr_wr_start) begin
                found  = 1;
                waited = n;
            end
        end
        chk("start_seen", 32'(found), 32'd1);
        if (found) begin
            chk("grant", 32'(ch_grant), 32'd1 << ch);
            chk("addr", ddr.pl_ddr_wr_addr, 32'(addr));
            chk("length", ddr.pl_ddr_wr_length, 32'(BB));
        end
    endtask

    // Follow one block through to its done pulse, checking every word.
    task automatic xfer_block(input int ch, input bit rand_afull,
                              output int first_en, output int last_en);
        int  words, run, max_run;
        bit  done_seen, af, nxt;
        words = 0; run = 0; max_run = 0; done_seen = 0; af = 0;
        first_en = 0; last_en = 0;
        for (int n = 0; n < 400 && !done_seen; n++) begin
            @(negedge pl_clk);
            if (ddr.pl_ddr_wr_en) begin
                chk("data", ddr.pl_ddr_wr_data, {8'(ch), 24'(exp_ptr[ch])});
                exp_ptr[ch]++;
                words++;
                if (words == 1) first_en = cyc;
                last_en = cyc;
                if (af) run++;
            end
            if (ch_blk_done != '0) begin
                done_seen = 1;
                chk("blk_done", 32'(ch_blk_done), 32'd1 << ch);
            end
            if (rand_afull) begin
                nxt = done_seen ? 1'b0 : ($urandom_range(0, 2) != 0);
                if (nxt && !af) run = ddr.pl_ddr_wr_en ? 1 : 0;
                af = nxt;
                ddr.ddr_wr_afull = af;
            end
            if (run > max_run) max_run = run;
        end
        ddr.ddr_wr_afull = 1'b0;
        chk("done_seen", 32'(done_seen), 32'd1);
        chk("words", 32'(words), 32'(BW));
        if (rand_afull) chk("afull_inflight_le2", 32'(max_run <= 2), 32'd1);
    endtask

    task automatic resync();
        for (int c = 0; c < NCH; c++) exp_ptr[c] = mptr[c];
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_start"},  32'(ddr.pl_ddr_wr_start), 32'd0);
        chk({pfx, "_addr"},   ddr.pl_ddr_wr_addr, 32'd0);
        chk({pfx, "_length"}, ddr.pl_ddr_wr_length, 32'd0);
        chk({pfx, "_en"},     32'(ddr.pl_ddr_wr_en), 32'd0);
        chk({pfx, "_data"},   ddr.pl_ddr_wr_data, 32'd0);
        chk({pfx, "_grant"},  32'(ch_grant), 32'd0);
        chk({pfx, "_rd_en"},  32'(ch_rd_en), 32'd0);
        chk({pfx, "_done"},   32'(ch_blk_done), 32'd0);
    endtask

    initial begin
        int w, f, l, prev_l, words;
        rst_n = 1'b0;
        ch_req = '0;
        ddr.ddr_wr_busy  = 1'b0;
        ddr.ddr_wr_afull = 1'b0;
        repeat (3) @(negedge pl_clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge pl_clk);
        resync();

        // Single request on ch2; dropping it after the command is ignored.
        ch_req = 4'b0100;
        wait_start(2, 2*RB, 4, w);
        chk("start_latency", 32'(w), 32'd1);
        ch_req = '0;
        xfer_block(2, 0, f, l);

        // Second ch2 block lands one block further into its region.
        ch_req = 4'b0100;
        wait_start(2, 2*RB + BB, 4, w);
        ch_req = '0;
        xfer_block(2, 0, f, l);

        // Reset clears offsets and rotation back to channel 0 first.
        @(negedge pl_clk);
        rst_n = 1'b0;
        @(negedge pl_clk);
        rst_n = 1'b1;
        resync();

        // All channels requesting: 0,1,2,3,0 with a 4-cycle gap.
        ch_req = 4'b1111;
        prev_l = 0;
        for (int i = 0; i < 5; i++) begin
            wait_start(i % 4, (i % 4) * RB + (i / 4) * BB, 10, w);
            if (i == 4) ch_req = '0;
            xfer_block(i % 4, 0, f, l);
            if (i > 0) chk("block_gap", 32'(f - prev_l - 1), 32'd4);
            prev_l = l;
        end

        // Random afull during a ch3 block.
        ch_req = 4'b1000;
        wait_start(3, 3*RB + BB, 4, w);
        ch_req = '0;
        xfer_block(3, 1, f, l);

        // Ring wrap on ch1 (offset already one block in).
        ch_req = 4'b0010;
        for (int j = 0; j < 4; j++) begin
            wait_start(1, RB + ((1 + j) % 3) * BB, 10, w);
            if (j == 3) ch_req = '0;
            xfer_block(1, 0, f, l);
        end

        // Busy holds off the command until released.
        ddr.ddr_wr_busy = 1'b1;
        ch_req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            @(negedge pl_clk);
            chk("busy_no_start", 32'(ddr.pl_ddr_wr_start), 32'd0);
            chk("busy_no_grant", 32'(ch_grant), 32'd0);
        end
        ddr.ddr_wr_busy = 1'b0;
        wait_start(0, 2*BB, 4, w);
        chk("busy_release_latency", 32'(w), 32'd1);
        ch_req = '0;
        xfer_block(0, 0, f, l);

        // Reset halfway through a ch2 block.
        ch_req = 4'b0100;
        wait_start(2, 2*RB + BB, 4, w);
        words = 0;
        for (int n = 0; n < 50 && words < BW/2; n++) begin
            @(negedge pl_clk);
            if (ddr.pl_ddr_wr_en) begin
                chk("abort_data", ddr.pl_ddr_wr_data, {8'd2, 24'(exp_ptr[2])});
                exp_ptr[2]++;
                words++;
            end
        end
        chk("abort_words_reached", 32'(words), 32'(BW/2));
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge pl_clk);
        rst_n = 1'b1;
        resync();
        wait_start(2, 2*RB, 4, w);
        chk("post_abort_latency", 32'(w), 32'd1);
        ch_req = '0;
        xfer_block(2, 0, f, l);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
